// File: rtl/radio_spi_tx.sv
// Byte FIFO feeding a mode-0 SPI master for the radio transmit path.
// Frames stay open across back-to-back bytes and while the packetiser holds pkt_active.
module radio_spi_tx #(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       send,
    input  logic       pkt_active,
    output logic       radio_busy,
    output logic       overflow,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       byte_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD} state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [7:0]       head;

    state_t           state;
    state_t           state_d;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_d;
    logic [3:0]       bit_cnt;
    logic [3:0]       bit_d;
    logic [6:0]       shreg;
    logic [6:0]       shreg_d;
    logic             cs_n_d;
    logic             sclk_d;
    logic             mosi_d;
    logic             done_d;
    logic             load;

    assign radio_busy = (count == FULL);
    assign fifo_empty = (count == '0);
    assign push       = send && !radio_busy;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= send && radio_busy;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            spi_cs_n  <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            state     <= state_d;
            div_cnt   <= div_d;
            bit_cnt   <= bit_d;
            shreg     <= shreg_d;
            spi_cs_n  <= cs_n_d;
            spi_sclk  <= sclk_d;
            spi_mosi  <= mosi_d;
            byte_done <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        div_d   = div_cnt;
        bit_d   = bit_cnt;
        shreg_d = shreg;
        cs_n_d  = spi_cs_n;
        sclk_d  = spi_sclk;
        mosi_d  = spi_mosi;
        done_d  = 1'b0;
        load    = 1'b0;
        pop     = 1'b0;

        unique case (state)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (!fifo_empty) begin
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_cnt == DIV_LAST) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    div_d = div_cnt + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = !spi_sclk;
                    bit_d  = bit_cnt + 4'd1;
                    // falling edge: advance data, or close out the byte
                    if (spi_sclk) begin
                        if (bit_cnt == 4'd15) begin
                            done_d = 1'b1;
                            if (!fifo_empty) begin
                                load = 1'b1;
                            end else if (pkt_active) begin
                                state_d = WAIT;
                            end else begin
                                state_d = HOLD;
                            end
                        end else begin
                            mosi_d  = shreg[6];
                            shreg_d = {shreg[5:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_cnt + DIV_W'(1);
                end
            end
            WAIT: begin
                sclk_d = 1'b0;
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end else if (!pkt_active) begin
                    div_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (div_cnt == DIV_LAST) begin
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_cnt + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            pop     = 1'b1;
            shreg_d = head[6:0];
            mosi_d  = head[7];
            bit_d   = '0;
            div_d   = '0;
        end
    end

endmodule

// File: doc/radio_spi_tx.md
RADIO_SPI_TX -- requirements
Module: radio_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 2: SPI half-period in clk cycles; minimum 1.
REQ-002 Parameter FIFO_DEPTH, default 4: byte FIFO entries; power of two, at least 2.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 tx_data  input  8  byte from the upstream packetiser.
REQ-007 send  input  1  tx_data is valid this cycle.
REQ-008 pkt_active  input  1  upstream packet in progress; connects to the packetiser's packet_valid.
REQ-009 radio_busy  output  1  FIFO full; upstream shall not assert send.
REQ-010 overflow  output  1  one-cycle pulse when send arrives while radio_busy is high.
REQ-011 spi_cs_n  output  1  radio chip select, active low.
REQ-012 spi_sclk  output  1  SPI clock, mode 0, idle low.
REQ-013 spi_mosi  output  1  serial data, MSB first.
REQ-014 byte_done  output  1  one-cycle pulse after the 8th sclk falling edge of each byte.

Function
REQ-015 Byte accept: send && !radio_busy writes tx_data into the FIFO at the rising edge.
REQ-016 radio_busy = (count == FIFO_DEPTH); it is decoded combinationally from the registered count.
REQ-017 send && radio_busy: the byte is dropped, overflow pulses next cycle, and FIFO contents are unchanged.
REQ-018 A push and a pop in the same cycle shall leave count unchanged, with both operations taking effect.
REQ-019 FSM states are IDLE, SETUP, SHIFT, WAIT and HOLD.
REQ-020 IDLE: cs_n=1, sclk=0, mosi=0.
- FIFO non-empty: at the next edge, cs_n goes 0 and the FSM enters SETUP.
REQ-021 SETUP: holds for CLK_DIV cycles.
- On exit: pop the head byte into the shift register, drive mosi=bit7, enter SHIFT.
REQ-022 SHIFT: sclk toggles every CLK_DIV cycles, starting low.
- mosi changes only on falling edges and is stable across each rising edge.
- Exactly 8 rising edges per byte.
REQ-023 Byte end, after the 8th falling edge: byte_done pulses, then the next state is chosen as follows.
- FIFO non-empty: pop the next byte in the same cycle, mosi=bit7, remain in SHIFT (no gap, no cs_n release).
- FIFO empty and pkt_active=1: enter WAIT.
- FIFO empty and pkt_active=0: enter HOLD.
REQ-024 WAIT: cs_n=0, sclk=0.
- FIFO non-empty: pop and re-enter SHIFT; this takes priority over pkt_active.
- Else pkt_active=0: enter HOLD.
REQ-025 HOLD: cs_n=0 for CLK_DIV cycles, then cs_n=1 and the FSM enters IDLE.
- A byte arriving during HOLD is transmitted in a new frame via IDLE.
REQ-026 Latency, first byte accepted at edge N with the FSM in IDLE:
- cs_n falls at edge N+1.
- First sclk rise at edge N+1+2*CLK_DIV.
REQ-027 Per-byte SPI time is 16*CLK_DIV cycles; back-to-back bytes have no extra cycles between them.
REQ-028 pkt_active only extends the frame; it never starts a frame when the FIFO is empty.
REQ-029 FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.

Reset
REQ-030 While rst=1, outputs are:
- cs_n=1, sclk=0, mosi=0
- radio_busy=0, overflow=0, byte_done=0
- FIFO empty, FSM in IDLE.
REQ-031 Reset asserted mid-byte or mid-frame aborts immediately.
- cs_n rises asynchronously and no partial byte is resumed.
- Bytes queued before reset are discarded.
REQ-032 The first accept after rst falls is at the first rising edge with rst=0.

Verification (CLK_DIV=2, FIFO_DEPTH=4)
REQ-033 Single byte: 0xAB with pkt_active=0.
- mosi on the 8 sclk rises reads 1,0,1,0,1,0,1,1.
- cs_n falls at N+1 and first sclk rise is at N+5.
- One byte_done pulse; cs_n high 2 cycles after the last fall.
REQ-034 Burst: bytes 0x01..0x08 presented, each only when radio_busy=0.
- All 8 bytes are shifted out in order within one cs_n frame, with no inter-byte gap.
- radio_busy is seen high at least once; overflow never pulses.
REQ-035 Overflow: fill the FIFO, then send 0xFF while radio_busy=1.
- overflow pulses once and 0xFF never appears on mosi.
REQ-036 Framing: 0x11, 20-cycle gap, 0x22.
- pkt_active=1 throughout: cs_n stays low across the gap.
- pkt_active=0: cs_n returns high between the two bytes.
REQ-037 Reset mid-byte: rst during the 4th bit of 0xC3 with 2 bytes queued.
- cs_n=1 and sclk=0 the same cycle.
- After release, no sclk activity until a new send.
